// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master (START, addr+rw, data, STOP).
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on scl_in.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WDATA,
    WACK, RDATA, MACK, STOP, DONE
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [1:0]  qtr;
  logic [2:0]  bit_idx;
  logic [7:0]  a_byte, d_byte, rx_sh;
  logic        nack, live;
  logic        busy, hold, tick, bit_end, smp;
  logic        hs, byte_st, last_bit;

  assign busy = (state != IDLE) && (state != DONE);

`ifdef I2C_CLK_STRETCH_EN
  // a released SCL still read low means the slave is stretching
  assign hold = qtr[1] & ~scl_oe & ~scl_in;
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold = 1'b0;
`endif

  assign tick     = busy && !hold && (cnt == DIV_M1);
  assign bit_end  = tick && (qtr == 2'd3);
  assign smp      = tick && (qtr == 2'd2);
  assign hs       = cmd_valid && cmd_ready;
  assign byte_st  = state inside {ADDR, WDATA, RDATA};
  assign last_bit = (bit_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      qtr       <= '0;
      bit_idx   <= '0;
      a_byte    <= '0;
      d_byte    <= '0;
      rx_sh     <= '0;
      nack      <= 1'b0;
      live      <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      live  <= 1'b1;
      state <= state_nx;
      if (hs) begin
        // handshake cycle counts as the first cycle of START
        cnt     <= 16'd1;
        qtr     <= '0;
        bit_idx <= '0;
        a_byte  <= {cmd_addr, cmd_rw};
        d_byte  <= cmd_wdata;
        nack    <= 1'b0;
        rx_sh   <= '0;
      end else if (tick) begin
        cnt <= '0;
        qtr <= qtr + 2'd1;
        if (bit_end)
          bit_idx <= byte_st ? bit_idx + 3'd1 : 3'd0;
      end else if (busy && !hold) begin
        cnt <= cnt + 16'd1;
      end
      if (smp && (state == AACK || state == WACK) && sda_in)
        nack <= 1'b1;
      if (smp && state == RDATA)
        rx_sh <= {rx_sh[6:0], sda_in};
      if (bit_end && state == STOP)
        rsp_rdata <= !a_byte[0] ? 8'h00 :
                     (nack ? rsp_rdata : rx_sh);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (hs) state_nx = START;
      START: if (bit_end) state_nx = ADDR;
      ADDR:  if (bit_end && last_bit) state_nx = AACK;
      AACK:
        if (bit_end) begin
          if (nack)           state_nx = STOP;
          else if (a_byte[0]) state_nx = RDATA;
          else                state_nx = WDATA;
        end
      WDATA: if (bit_end && last_bit) state_nx = WACK;
      WACK:  if (bit_end) state_nx = STOP;
      RDATA: if (bit_end && last_bit) state_nx = MACK;
      MACK:  if (bit_end) state_nx = STOP;
      STOP:  if (bit_end) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    cmd_ready = (state == IDLE) && live;
    rsp_valid = (state == DONE);
    rsp_nack  = (state == DONE) && nack;
    unique case (state)
      START: begin
        sda_oe = qtr[1];
        scl_oe = (qtr == 2'd3);
      end
      ADDR: begin
        scl_oe = ~qtr[1];
        sda_oe = ~a_byte[3'd7 - bit_idx];
      end
      WDATA: begin
        scl_oe = ~qtr[1];
        sda_oe = ~d_byte[3'd7 - bit_idx];
      end
      AACK, WACK, RDATA, MACK:
        scl_oe = ~qtr[1];
      STOP: begin
        scl_oe = ~qtr[1];
        sda_oe = (qtr != 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: random and directed transactions against a
// bus-level I2C slave model and a transaction-level expectation.
module tb_i2c_master_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, rsp_nack;
  logic       scl_oe, sda_oe;
  logic [7:0] rsp_rdata;
  logic       scl, sda;
  logic       sl_sda = 1'b1;
  logic       stretch = 1'b0;

  assign scl = ~scl_oe & ~stretch;
  assign sda = ~sda_oe & sl_sda;

  i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .scl_in    (scl),
    .sda_in    (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transaction under test and slave behaviour
  logic       e_rw = 1'b0;
  logic [6:0] e_addr = '0;
  logic [7:0] e_wd = '0;
  logic [7:0] e_rb = '0;
  logic       e_aack = 1'b1;
  logic       e_dack = 1'b1;
  int         e_str = 0;
  logic [7:0] exp_rd = '0;
  int         hs_cyc = 0;
  int         st0 = 0;

  // slave: sees the bus only through sampled SCL/SDA levels
  int         nbit = 100;
  int         stop_nb = 0;
  int         stops = 0;
  int         st_cnt = 0;
  logic       act = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       m_bit = 1'b0;
  logic [7:0] a_sh = '0;
  logic [7:0] d_sh = '0;

  always @(negedge clk) begin : slave_model
    int nb;
    int nx;
    nb = nbit;
    if (p_scl && scl && p_sda && !sda) begin
      act <= 1'b1;
      nb = 0;
    end
    if (p_scl && scl && !p_sda && sda) begin
      act     <= 1'b0;
      stop_nb <= nb;
      stops   <= stops + 1;
    end
    if (!p_scl && scl) begin
      nb = nb + 1;
      if (nb <= 8)
        a_sh <= {a_sh[6:0], sda};
      else if (nb >= 10 && nb <= 17)
        d_sh <= {d_sh[6:0], sda};
      if (nb == 18)
        m_bit <= sda;
    end
    if (p_scl && !scl && act) begin
      nx = nb + 1;
      if (nx == 9)
        sl_sda <= ~e_aack;
      else if (nx >= 10 && nx <= 17 && a_sh[0] && e_aack)
        sl_sda <= e_rb[3'(17 - nx)];
      else if (nx == 18 && !a_sh[0])
        sl_sda <= ~e_dack;
      else
        sl_sda <= 1'b1;
      if (nx == 9 && e_str > 0) begin
        stretch <= 1'b1;
        st_cnt  <= 0;
      end
    end else if (stretch && !scl_oe) begin
      if (st_cnt == e_str)
        stretch <= 1'b0;
      st_cnt <= st_cnt + 1;
    end
    nbit  <= nb;
    p_scl <= scl;
    p_sda <= sda;
  end

  task automatic issue();
    int n;
    cmd_rw    = e_rw;
    cmd_addr  = e_addr;
    cmd_wdata = e_wd;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hs_ready", cmd_ready, 1);
    hs_cyc = cyc;
    st0    = stops;
  endtask

  task automatic complete(input int glitch);
    int   n;
    int   lat;
    logic en;
    lat = (e_aack ? 80 : 44) * DIV;
`ifdef I2C_CLK_STRETCH_EN
    lat += e_str;
`endif
    en = !e_aack || (!e_rw && !e_dack);
    if (!e_rw)
      exp_rd = 8'h00;
    else if (e_aack)
      exp_rd = e_rb;
    n = 0;
    while (!rsp_valid && n < 4000) begin
      if (glitch != 0 && n == glitch) begin
        cmd_valid = 1'b1;
        cmd_rw    = 1'($urandom);
        cmd_addr  = 7'($urandom);
        cmd_wdata = 8'($urandom);
      end
      if (glitch != 0 && n == glitch + 3)
        cmd_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", rsp_valid, 1);
    chk("latency", cyc - hs_cyc, lat);
    chk("nack", rsp_nack, en);
    chk("rdata", rsp_rdata, exp_rd);
    chk("addr_byte", a_sh, {e_addr, e_rw});
    if (e_aack && !e_rw)
      chk("wr_byte", d_sh, e_wd);
    if (e_aack && e_rw)
      chk("mack", m_bit, 1);
    chk("scl_rises", stop_nb, e_aack ? 19 : 10);
    chk("stops", stops - st0, 1);
    @(negedge clk);
    chk("pulse", rsp_valid, 0);
    chk("ready", cmd_ready, 1);
  endtask

  task automatic txn(input logic rw, input logic [6:0] a,
                     input logic [7:0] d, input logic [7:0] rb,
                     input logic aack, input logic dack,
                     input int str, input int glitch);
    e_rw   = rw;
    e_addr = a;
    e_wd   = d;
    e_rb   = rb;
    e_aack = aack;
    e_dack = dack;
    e_str  = str;
    issue();
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy", cmd_ready, 0);
    complete(glitch);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_nack", rsp_nack, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", cmd_ready, 1);

    txn(1'b0, 7'h01, 8'hA5, 8'h00, 1'b1, 1'b1, 0, 0);
    txn(1'b1, 7'h01, 8'h00, 8'h3C, 1'b1, 1'b1, 0, 0);
    txn(1'b0, 7'h22, 8'h55, 8'h00, 1'b0, 1'b1, 0, 0);

    for (int i = 0; i < 10; i++)
      txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          0, $urandom_range(10, 150));

`ifdef I2C_CLK_STRETCH_EN
    txn(1'b0, 7'h01, 8'hA5, 8'h00, 1'b1, 1'b1, 10, 0);
    e_str = 0;
`endif

    // back-to-back: cmd_valid stays high across both commands
    e_rw = 1'b0; e_addr = 7'h33; e_wd = 8'h96;
    e_aack = 1'b1; e_dack = 1'b1; e_str = 0;
    issue();
    @(negedge clk);
    chk("b2b_busy", cmd_ready, 0);
    cmd_rw = 1'b1; cmd_addr = 7'h5A; cmd_wdata = 8'h00;
    complete(0);
    hs_cyc = cyc;
    st0    = stops;
    e_rw = 1'b1; e_addr = 7'h5A; e_wd = 8'h00; e_rb = 8'hC7;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_busy2", cmd_ready, 0);
    complete(0);

    // reset abort inside the write data byte
    e_rw = 1'b0; e_addr = 7'h11; e_wd = 8'hE0;
    e_aack = 1'b1; e_dack = 1'b1;
    issue();
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < hs_cyc + 13 * 4 * DIV + 6) @(negedge clk);
    chk("abort_scl_pre", scl_oe, 1);
    chk("abort_sda_pre", sda_oe, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_scl", scl_oe, 0);
    chk("abort_sda", sda_oe, 0);
    chk("abort_rv", rsp_valid, 0);
    chk("abort_ready0", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready1", cmd_ready, 1);
    exp_rd = 8'h00;
    chk("abort_rdata", rsp_rdata, exp_rd);
    seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 0);

    txn(1'b1, 7'h6E, 8'h00, 8'h81, 1'b1, 1'b1, 0, 0);
    txn(1'b0, 7'h6E, 8'h7E, 8'h00, 1'b1, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
